key_scan: RTL and testbench
===========================

KEY_SCAN -- requirements
Module: key_scan

Interface
REQ-001 SHALL have parameter NKEY, default 4, number of pushbutton inputs.
REQ-002 SHALL have parameter DB_CYCLES, default 1000000, debounce stability window in clk cycles (20 ms at 50 MHz).
REQ-003 SHALL have parameter RPT_DELAY, default 25000000, held time before first auto-repeat (500 ms).
REQ-004 SHALL have parameter RPT_PERIOD, default 5000000, interval between auto-repeats (100 ms).
REQ-005 SHALL have port clk  input  1  system clock, 50 MHz.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port key_n  input  NKEY  raw pushbuttons, active-low, asynchronous to clk.
REQ-008 SHALL have port key_state  output  NKEY  debounced level, 1 = pressed.
REQ-009 SHALL have port key_press  output  NKEY  one-cycle pulse per accepted press (and per repeat).
REQ-010 SHALL have port key_release  output  NKEY  one-cycle pulse per accepted release.

Function
REQ-011 SHALL pass each key_n bit through a 2-flop synchronizer and invert it, giving 2 cycles of input latency.
REQ-012 SHALL run an independent FSM per key with states IDLE, PRESS_DB, HELD, RELEASE_DB.
REQ-013 IDLE: synced pressed -> PRESS_DB with counter cleared; otherwise stay.
REQ-014 PRESS_DB: counter increments each cycle while pressed; on reaching DB_CYCLES-1 -> HELD; any released sample -> IDLE, no output.
REQ-015 HELD: synced released -> RELEASE_DB with counter cleared; otherwise stay.
REQ-016 RELEASE_DB: counter increments while released; on reaching DB_CYCLES-1 -> IDLE; any pressed sample -> HELD, no output.
REQ-017 key_state SHALL be 1 exactly in HELD and RELEASE_DB.
REQ-018 key_press SHALL pulse the cycle after the PRESS_DB->HELD transition, i.e. DB_CYCLES+2 cycles after a clean press edge at key_n.
REQ-019 key_release SHALL pulse the cycle after the RELEASE_DB->IDLE transition.
REQ-020 Counters SHALL be ceil(log2(max(DB_CYCLES,RPT_DELAY,RPT_PERIOD)+1)) bits wide and never wrap; they saturate at the compare value.
REQ-021 Keys SHALL be fully independent; simultaneous events on several keys produce simultaneous pulses on the matching bits.
REQ-022 Bounce shorter than DB_CYCLES on either edge SHALL produce no pulse and no key_state change.

Reset
REQ-023 rst_n low SHALL force all FSMs to IDLE, clear counters and synchronizers to released, and drive key_state, key_press, key_release to 0 immediately.
REQ-024 A key held while rst_n deasserts SHALL be treated as a new press and produce key_press after full debounce.
REQ-025 Reset mid-debounce or mid-HELD SHALL emit no key_release.

Configuration
REQ-026 Macro KEY_SCAN_REPEAT_EN SHALL compile in auto-repeat.
REQ-027 With KEY_SCAN_REPEAT_EN: in HELD, a repeat counter SHALL issue an extra key_press RPT_DELAY cycles after the initial pulse, then every RPT_PERIOD cycles, stopping on leaving HELD; RELEASE_DB->HELD bounce restarts the repeat timer at RPT_DELAY.
REQ-028 Without KEY_SCAN_REPEAT_EN: exactly one key_press per accepted press; no repeat counter logic present.

Structure
REQ-029 Package key_scan_pkg SHALL hold the FSM state typedef and default timing constants (DB_CYCLES, RPT_DELAY, RPT_PERIOD at 50 MHz).
REQ-030 Per-key logic SHALL be sub-module key_scan_ch, instantiated NKEY times by key_scan via generate loop.

Verification (sim with DB_CYCLES=8, RPT_DELAY=40, RPT_PERIOD=10)
REQ-031 Clean press key_n[0] 1->0 held 60 cycles -> key_press[0] single pulse at cycle 10, key_state[0]=1 from cycle 10.
REQ-032 key_n[1] toggling every 3 cycles for 30 cycles then stable high -> no pulses, key_state[1]=0 throughout.
REQ-033 Release after stable press, with 4-cycle bounce low -> key_state stays 1 during bounce, single key_release 10 cycles after final release edge.
REQ-034 Keys 0 and 3 pressed same cycle -> key_press=4'b1001 in one cycle.
REQ-035 rst_n pulled low during HELD -> outputs 0 asynchronously, no key_release; key still held after rst_n high -> key_press 10 cycles later.
REQ-036 KEY_SCAN_REPEAT_EN defined, key held 100 cycles -> key_press pulses at 10, 50, 60, 70, 80, 90, 100; undefined -> only at 10.

Source files
------------

// File: rtl/key_scan_pkg.sv
// Shared types and default timing for the key_scan pushbutton scanner.
// Auto-repeat is compiled in by defining KEY_SCAN_REPEAT_EN.
package key_scan_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_DB   = 2'd1,
      HELD       = 2'd2,
      RELEASE_DB = 2'd3
   } key_fsm_t;

   // Defaults assume a 50 MHz clock: 20 ms debounce, 500 ms first repeat, 100 ms repeat.
   localparam int DEF_DB_CYCLES  = 1000000;
   localparam int DEF_RPT_DELAY  = 25000000;
   localparam int DEF_RPT_PERIOD = 5000000;

   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/key_scan_ch.sv
// One debounced pushbutton channel: synchronizer, press/release FSM, optional
// auto-repeat (KEY_SCAN_REPEAT_EN).
module key_scan_ch
   import key_scan_pkg::*;
#(
   parameter int DB_CYCLES  = DEF_DB_CYCLES,
   parameter int RPT_DELAY  = DEF_RPT_DELAY,
   parameter int RPT_PERIOD = DEF_RPT_PERIOD
)(
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic key_state,
   output logic key_press,
   output logic key_release
);

   localparam int CW = cnt_width(DB_CYCLES, RPT_DELAY, RPT_PERIOD);
   localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

   logic [1:0]    sync_r;
   logic          pressed_s;
   key_fsm_t      state_r;
   logic [CW-1:0] cnt_r;

`ifdef KEY_SCAN_REPEAT_EN
   localparam logic [CW-1:0] RPT_DELAY_LAST  = CW'(RPT_DELAY - 1);
   localparam logic [CW-1:0] RPT_PERIOD_LAST = CW'(RPT_PERIOD - 1);

   // Set once the first repeat has fired; later gaps use the shorter period.
   logic          rpt_armed_r;
   logic [CW-1:0] rpt_last_s;

   assign rpt_last_s = rpt_armed_r ? RPT_PERIOD_LAST : RPT_DELAY_LAST;
`endif

   // Two-flop synchronizer on the raw active-low input; resets to released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= 2'b11;
      end else begin
         sync_r <= {sync_r[0], key_n};
      end
   end

   assign pressed_s = ~sync_r[1];

   // Debounce FSM with registered level and pulse outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         cnt_r       <= '0;
         key_state   <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
`ifdef KEY_SCAN_REPEAT_EN
         rpt_armed_r <= 1'b0;
`endif
      end else begin
         key_press   <= 1'b0;
         key_release <= 1'b0;
         case (state_r)
            IDLE: begin
               cnt_r <= '0;
               if (pressed_s) begin
                  state_r <= PRESS_DB;
               end else begin
                  state_r <= IDLE;
               end
            end
            PRESS_DB: begin
               if (!pressed_s) begin
                  state_r <= IDLE;
                  cnt_r   <= '0;
               end else if (cnt_r >= DB_LAST) begin
                  state_r   <= HELD;
                  cnt_r     <= '0;
                  key_state <= 1'b1;
                  key_press <= 1'b1;
`ifdef KEY_SCAN_REPEAT_EN
                  rpt_armed_r <= 1'b0;
`endif
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            HELD: begin
               if (!pressed_s) begin
                  state_r <= RELEASE_DB;
                  cnt_r   <= '0;
               end else begin
`ifdef KEY_SCAN_REPEAT_EN
                  if (cnt_r >= rpt_last_s) begin
                     cnt_r       <= '0;
                     key_press   <= 1'b1;
                     rpt_armed_r <= 1'b1;
                  end else begin
                     cnt_r <= cnt_r + CW'(1);
                  end
`else
                  cnt_r <= '0;
`endif
               end
            end
            RELEASE_DB: begin
               if (pressed_s) begin
                  // Release bounce: back to HELD silently, repeat timer restarts.
                  state_r <= HELD;
                  cnt_r   <= '0;
`ifdef KEY_SCAN_REPEAT_EN
                  rpt_armed_r <= 1'b0;
`endif
               end else if (cnt_r >= DB_LAST) begin
                  state_r     <= IDLE;
                  cnt_r       <= '0;
                  key_state   <= 1'b0;
                  key_release <= 1'b1;
               end else begin
                  cnt_r <= cnt_r + CW'(1);
               end
            end
            default: begin
               state_r   <= IDLE;
               cnt_r     <= '0;
               key_state <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/key_scan.sv
// NKEY-wide debounced pushbutton scanner built from independent key_scan_ch
// channels; auto-repeat is enabled by defining KEY_SCAN_REPEAT_EN.
module key_scan
   import key_scan_pkg::*;
#(
   parameter int NKEY       = 4,
   parameter int DB_CYCLES  = DEF_DB_CYCLES,
   parameter int RPT_DELAY  = DEF_RPT_DELAY,
   parameter int RPT_PERIOD = DEF_RPT_PERIOD
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NKEY-1:0] key_n,
   output logic [NKEY-1:0] key_state,
   output logic [NKEY-1:0] key_press,
   output logic [NKEY-1:0] key_release
);

   for (genvar g = 0; g < NKEY; g++) begin : g_ch
      key_scan_ch #(
         .DB_CYCLES  (DB_CYCLES),
         .RPT_DELAY  (RPT_DELAY),
         .RPT_PERIOD (RPT_PERIOD)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .key_n       (key_n[g]),
         .key_state   (key_state[g]),
         .key_press   (key_press[g]),
         .key_release (key_release[g])
      );
   end

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan with DB_CYCLES=8, RPT_DELAY=40, RPT_PERIOD=10.
module tb_key_scan;

   logic       clk;
   logic       rst_n;
   logic [3:0] key_n;
   logic [3:0] key_state;
   logic [3:0] key_press;
   logic [3:0] key_release;

   int pass_cnt  = 0;
   int total_cnt = 0;

   key_scan #(
      .NKEY       (4),
      .DB_CYCLES  (8),
      .RPT_DELAY  (40),
      .RPT_PERIOD (10)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_n       (key_n),
      .key_state   (key_state),
      .key_press   (key_press),
      .key_release (key_release)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] kn;
      int         ncyc;
      logic [3:0] st;
      logic [3:0] pr;
      logic [3:0] rl;
   } row_t;

   row_t rows[$];

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one clock and sample 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int npress;
      int nrel;
      logic exp_p;

      // Cycle numbering: stimulus applied just before edge 0; a view after step k shows cycle k-1.
      rows.push_back(row_t'{4'b0110, 10, 4'b0000, 4'b0000, 4'b0000});
      rows.push_back(row_t'{4'b0110,  1, 4'b1001, 4'b1001, 4'b0000});
      rows.push_back(row_t'{4'b0110,  1, 4'b1001, 4'b0000, 4'b0000});
      rows.push_back(row_t'{4'b1111,  3, 4'b1001, 4'b0000, 4'b0000});
      rows.push_back(row_t'{4'b0110,  4, 4'b1001, 4'b0000, 4'b0000});
      rows.push_back(row_t'{4'b1111, 10, 4'b1001, 4'b0000, 4'b0000});
      rows.push_back(row_t'{4'b1111,  1, 4'b0000, 4'b0000, 4'b1001});
      rows.push_back(row_t'{4'b1111,  1, 4'b0000, 4'b0000, 4'b0000});
      rows.push_back(row_t'{4'b1011, 10, 4'b0000, 4'b0000, 4'b0000});
      rows.push_back(row_t'{4'b1011,  1, 4'b0100, 4'b0100, 4'b0000});
      rows.push_back(row_t'{4'b1111, 11, 4'b0000, 4'b0000, 4'b0100});
      rows.push_back(row_t'{4'b1111,  1, 4'b0000, 4'b0000, 4'b0000});
      rows.push_back(row_t'{4'b1101,  7, 4'b0000, 4'b0000, 4'b0000});
      rows.push_back(row_t'{4'b1111, 12, 4'b0000, 4'b0000, 4'b0000});

      key_n = 4'b1111;
      rst_n = 1'b0;
      step();
      step();
      chk("reset_state", key_state, 4'b0000);
      chk("reset_press", key_press, 4'b0000);
      chk("reset_release", key_release, 4'b0000);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step();

      // Table: simultaneous keys 0/3, release bounce, single key, short glitch.
      for (int i = 0; i < rows.size(); i++) begin
         key_n = rows[i].kn;
         for (int c = 0; c < rows[i].ncyc; c++) begin
            step();
            if (c == rows[i].ncyc - 1) begin
               chk($sformatf("row%0d_state", i), key_state, rows[i].st);
               chk($sformatf("row%0d_press", i), key_press, rows[i].pr);
               chk($sformatf("row%0d_release", i), key_release, rows[i].rl);
            end else begin
               chk($sformatf("row%0d_mid_press", i), key_press, 4'b0000);
               chk($sformatf("row%0d_mid_release", i), key_release, 4'b0000);
            end
         end
      end

      // key_n[1] toggling every 3 cycles: nothing may come out.
      for (int t = 0; t < 10; t++) begin
         key_n = (t % 2 == 0) ? 4'b1101 : 4'b1111;
         for (int c = 0; c < 3; c++) begin
            step();
            chk("bounce_state", key_state, 4'b0000);
            chk("bounce_press", key_press, 4'b0000);
            chk("bounce_release", key_release, 4'b0000);
         end
      end
      key_n = 4'b1111;
      for (int c = 0; c < 12; c++) begin
         step();
         chk("bounce_tail_state", key_state, 4'b0000);
         chk("bounce_tail_press", key_press, 4'b0000);
      end

      // Long hold on key 0: one press, or press plus auto-repeats.
      key_n = 4'b1110;
      for (int c = 0; c <= 100; c++) begin
         step();
         exp_p = (c == 10);
`ifdef KEY_SCAN_REPEAT_EN
         if (c >= 50 && (c - 50) % 10 == 0) exp_p = 1'b1;
`endif
         chk($sformatf("hold_press_c%0d", c), key_press, {3'b000, exp_p});
         chk($sformatf("hold_state_c%0d", c), key_state, (c >= 10) ? 4'b0001 : 4'b0000);
      end
      key_n = 4'b1111;
      nrel = 0;
      npress = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         if (key_release == 4'b0001) nrel++;
         if (key_press != 4'b0000) npress++;
      end
      chk("hold_release_count", nrel[3:0], 4'd1);
      chk("hold_after_press_count", npress[3:0], 4'd0);
      chk("hold_end_state", key_state, 4'b0000);

      // Reset during HELD: immediate clear, no release, fresh press afterwards.
      key_n = 4'b1110;
      for (int c = 0; c < 11; c++) step();
      chk("rst_pre_state", key_state, 4'b0001);
      rst_n = 1'b0;
      #1;
      chk("rst_async_state", key_state, 4'b0000);
      chk("rst_async_press", key_press, 4'b0000);
      chk("rst_async_release", key_release, 4'b0000);
      for (int c = 0; c < 3; c++) begin
         step();
         chk("rst_hold_release", key_release, 4'b0000);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step();
         chk("rst_after_release", key_release, 4'b0000);
         chk("rst_after_press", key_press, 4'b0000);
      end
      step();
      chk("rst_repress_press", key_press, 4'b0001);
      chk("rst_repress_state", key_state, 4'b0001);
      key_n = 4'b1111;
      for (int c = 0; c < 14; c++) step();
      chk("final_state", key_state, 4'b0000);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
